ex_stage_mc: RTL and testbench

Parametrised pipelined execute stage with an iterative multiply/divide unit and HI/LO registers. It decodes `alu_op`/`funct`, selects the second operand, computes the write-back register and branch target, and registers everything into the EX/MEM boundary. It sits between the ID/EX register and the MEM stage. Multi-cycle operations stall the front end through `ready_out`.

---
 rtl/ex_pkg.sv | 30 +++
 rtl/ex_muldiv.sv | 127 ++++++++++++
 rtl/ex_stage_mc.sv | 188 ++++++++++++++++++
 tb/tb_ex_stage_mc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the multi-cycle execute stage: alu_op/funct codes,
// internal ALU control and the mul/div sequencer state.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT,
    ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_DIV, ALU_NONE
  } alu_ctl_e;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  typedef enum logic {MD_MULT, MD_DIV} md_op_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative signed multiply/divide with HI/LO. Works on magnitudes for
// DATA_WIDTH cycles, then fixes signs in DONE. Divider present only with EX_DIV_EN.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         start,
  input  md_op_e                       op,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic                         idle,
  output logic                         done,
  output logic [DATA_WIDTH-1:0]        res_lo,
  output logic [DATA_WIDTH-1:0]        hi,
  output logic [DATA_WIDTH-1:0]        lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  md_state_e      state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] work;
  logic [W-1:0]   opnd;
  logic           neg_q;
  logic [W-1:0]   mag_a, mag_b, res_hi;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] step, fix_prod;

  assign mag_a = a[W-1] ? -a : a;
  assign mag_b = b[W-1] ? -b : b;

  // Upper half of work is the accumulator (mult) or partial remainder (div).
  assign mul_sum = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, opnd} : {(W+1){1'b0}});

`ifdef EX_DIV_EN
  logic         is_div, neg_r, div0;
  logic [W-1:0] dvd;
  logic [W:0]   shifted, trial;

  assign shifted = {work[2*W-1:W], work[W-1]};
  assign trial   = shifted - {1'b0, opnd};
`else
  logic unused_op;
  assign unused_op = op;
`endif

  always_comb begin
    step = {mul_sum, work[W-1:1]};
`ifdef EX_DIV_EN
    if (is_div)
      step = trial[W] ? {shifted[W-1:0], work[W-2:0], 1'b0}
                      : {trial[W-1:0],   work[W-2:0], 1'b1};
`endif
  end

  always_comb begin
    fix_prod = neg_q ? -work : work;
    res_hi   = fix_prod[2*W-1:W];
    res_lo   = fix_prod[W-1:0];
`ifdef EX_DIV_EN
    if (is_div) begin
      if (div0) begin
        res_lo = '1;
        res_hi = dvd;
      end else begin
        res_lo = neg_q ? -work[W-1:0]   : work[W-1:0];
        res_hi = neg_r ? -work[2*W-1:W] : work[2*W-1:W];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state <= MD_BUSY;
          cnt   <= '0;
          neg_q <= a[W-1] ^ b[W-1];
`ifdef EX_DIV_EN
          is_div <= (op == MD_DIV);
          neg_r  <= a[W-1];
          div0   <= (b == '0);
          dvd    <= a;
          if (op == MD_DIV) begin
            opnd <= mag_b;
            work <= {{W{1'b0}}, mag_a};
          end else begin
            opnd <= mag_a;
            work <= {{W{1'b0}}, mag_b};
          end
`else
          opnd <= mag_a;
          work <= {{W{1'b0}}, mag_b};
`endif
        end
        MD_BUSY: begin
          work <= step;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(W-1)) state <= MD_DONE;
        end
        MD_DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign idle = (state == MD_IDLE);
  assign done = (state == MD_DONE);

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: decode, ALU, operand/destination muxes, branch target and the
// EX/MEM register; mult/div run in ex_muldiv (divide compiled in with EX_DIV_EN).
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PC_WIDTH       = 6,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int BR_SHIFT       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [DATA_WIDTH-1:0]     readd1,
  input  logic [DATA_WIDTH-1:0]     readd2,
  input  logic [DATA_WIDTH-1:0]     sign_ext,
  input  logic [PC_WIDTH-1:0]       pc_next,
  input  logic [1:0]                alu_op,
  input  logic [5:0]                funct,
  input  logic                      alu_src,
  input  logic                      reg_dst,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [REG_ADDR_WIDTH-1:0] rt,
  output logic                      valid_out,
  output logic                      wb_en,
  output logic [DATA_WIDTH-1:0]     alu_result,
  output logic                      zero,
  output logic                      ovf,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [PC_WIDTH-1:0]       branch_target
);

  localparam int W  = DATA_WIDTH;
  localparam int EW = PC_WIDTH + DATA_WIDTH + BR_SHIFT;

  function automatic logic add_ovf(input logic signed [W-1:0] x, y, s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [W-1:0] x, y, s);
    return (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  logic signed [W-1:0]       op_a, op_b, sum, diff, alu_res;
  logic                      alu_ovf, alu_wb, is_md, accept, md_start;
  logic                      md_idle, md_done;
  logic [W-1:0]              md_res_lo, md_hi, md_lo;
  md_op_e                    md_op;
  alu_ctl_e                  ctl;
  logic [REG_ADDR_WIDTH-1:0] wreg, wreg_hold;
  logic [PC_WIDTH-1:0]       off_pc, tgt, bt_hold;

  logic                      vld_p1, wb_p1, zero_p1, ovf_p1;
  logic [W-1:0]              res_p1;
  logic [REG_ADDR_WIDTH-1:0] wreg_p1;
  logic [PC_WIDTH-1:0]       bt_p1;

  assign op_a = readd1;
  assign op_b = alu_src ? sign_ext : readd2;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign wreg = reg_dst ? rd : rt;

  // Offset is sign-extended before the shift so the target wraps modulo 2^PC_WIDTH.
  assign off_pc = PC_WIDTH'(EW'($signed(sign_ext)) << BR_SHIFT);
  assign tgt    = pc_next + off_pc;

  always_comb begin
    ctl = ALU_NONE;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_SLT: ctl = ALU_SLT;
      default: begin
        case (funct)
          FN_ADD:  ctl = ALU_ADD;
          FN_SUB:  ctl = ALU_SUB;
          FN_AND:  ctl = ALU_AND;
          FN_OR:   ctl = ALU_OR;
          FN_NOR:  ctl = ALU_NOR;
          FN_SLT:  ctl = ALU_SLT;
          FN_MFHI: ctl = ALU_MFHI;
          FN_MFLO: ctl = ALU_MFLO;
          FN_MULT: ctl = ALU_MULT;
`ifdef EX_DIV_EN
          FN_DIV:  ctl = ALU_DIV;
`endif
          default: ctl = ALU_NONE;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_wb  = 1'b1;
    case (ctl)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf(op_a, op_b, sum);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf(op_a, op_b, diff);
      end
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = (op_a < op_b) ? W'(1) : W'(0);
      ALU_MFHI: alu_res = md_hi;
      ALU_MFLO: alu_res = md_lo;
      default:  alu_wb  = 1'b0;
    endcase
  end

  assign is_md     = (ctl == ALU_MULT) || (ctl == ALU_DIV);
  assign md_op     = (ctl == ALU_DIV) ? MD_DIV : MD_MULT;
  assign accept    = valid_in && md_idle && !flush;
  assign md_start  = accept && is_md;
  assign ready_out = md_idle;

  ex_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .op     (md_op),
    .a      (op_a),
    .b      (op_b),
    .idle   (md_idle),
    .done   (md_done),
    .res_lo (md_res_lo),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge clk) begin
    if (md_start) begin
      wreg_hold <= wreg;
      bt_hold   <= tgt;
    end
  end

  // EX/MEM boundary (p1): single-cycle results or a retiring mult/div.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      wb_p1   <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      wreg_p1 <= '0;
      bt_p1   <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (md_done) begin
      vld_p1  <= 1'b1;
      wb_p1   <= 1'b0;
      res_p1  <= md_res_lo;
      zero_p1 <= (md_res_lo == '0);
      ovf_p1  <= 1'b0;
      wreg_p1 <= wreg_hold;
      bt_p1   <= bt_hold;
    end else if (accept && !is_md) begin
      vld_p1  <= 1'b1;
      wb_p1   <= alu_wb;
      res_p1  <= alu_res;
      zero_p1 <= (alu_res == '0);
      ovf_p1  <= alu_ovf;
      wreg_p1 <= wreg;
      bt_p1   <= tgt;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign valid_out     = vld_p1;
  assign wb_en         = wb_p1;
  assign alu_result    = res_p1;
  assign zero          = zero_p1;
  assign ovf           = ovf_p1;
  assign write_reg     = wreg_p1;
  assign branch_target = bt_p1;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Randomized and directed bench for ex_stage_mc against an integer-arithmetic
// reference model with its own HI/LO copy.
module tb_ex_stage_mc;

  logic       clk = 1'b0;
  logic       rst, flush, valid_in, ready_out;
  logic [7:0] readd1, readd2, sign_ext;
  logic [5:0] pc_next;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       alu_src, reg_dst;
  logic [2:0] rd, rt;
  logic       valid_out, wb_en, zero, ovf;
  logic [7:0] alu_result;
  logic [2:0] write_reg;
  logic [5:0] branch_target;

  always #5 clk = ~clk;

  ex_stage_mc #(.DATA_WIDTH(8), .PC_WIDTH(6), .REG_ADDR_WIDTH(3), .BR_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
    .readd1(readd1), .readd2(readd2), .sign_ext(sign_ext), .pc_next(pc_next),
    .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .reg_dst(reg_dst),
    .rd(rd), .rt(rt), .valid_out(valid_out), .wb_en(wb_en), .alu_result(alu_result),
    .zero(zero), .ovf(ovf), .write_reg(write_reg), .branch_target(branch_target)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
    logic       wb;
    logic       md;
    logic [7:0] hi;
    logic [7:0] lo;
  } exp_t;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] hi_m = 8'h00;
  logic [7:0] lo_m = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] aop, input logic [5:0] fn,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, r, q, m;
    logic [5:0] f;
    sa = $signed(a);
    sb = $signed(b);
    e.res = 8'h00; e.ovf = 1'b0; e.wb = 1'b1; e.md = 1'b0; e.hi = hi_m; e.lo = lo_m;
    f = (aop == 2'b00) ? 6'h20 : (aop == 2'b01) ? 6'h22 : (aop == 2'b11) ? 6'h2A : fn;
    case (f)
      6'h20: begin r = sa + sb; e.res = r[7:0]; e.ovf = (r > 127) || (r < -128); end
      6'h22: begin r = sa - sb; e.res = r[7:0]; e.ovf = (r > 127) || (r < -128); end
      6'h24: e.res = a & b;
      6'h25: e.res = a | b;
      6'h27: e.res = ~(a | b);
      6'h2A: e.res = (sa < sb) ? 8'd1 : 8'd0;
      6'h10: e.res = hi_m;
      6'h12: e.res = lo_m;
      6'h18: begin
        r = sa * sb; e.hi = r[15:8]; e.lo = r[7:0];
        e.res = e.lo; e.wb = 1'b0; e.md = 1'b1;
      end
`ifdef EX_DIV_EN
      6'h1A: begin
        if (sb == 0) begin e.lo = 8'hFF; e.hi = a; end
        else begin q = sa / sb; m = sa % sb; e.lo = q[7:0]; e.hi = m[7:0]; end
        e.res = e.lo; e.wb = 1'b0; e.md = 1'b1;
      end
`endif
      default: e.wb = 1'b0;
    endcase
    return e;
  endfunction

  // Called just after a rising edge; returns just after a later rising edge.
  task automatic exec(input string tag, input logic [1:0] aop, input logic [5:0] fn,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                      input logic src, input logic dst);
    exp_t e;
    logic [2:0] rdv, rtv, wexp;
    logic [5:0] pcv, btexp;
    int low;
    bit seen;
    rdv = 3'($urandom); rtv = 3'($urandom); pcv = 6'($urandom);
    e = model(aop, fn, a, src ? imm : b);
    wexp = dst ? rdv : rtv;
    btexp = 6'(pcv + imm);
    readd1 = a; readd2 = b; sign_ext = imm; alu_op = aop; funct = fn;
    alu_src = src; reg_dst = dst; rd = rdv; rt = rtv; pc_next = pcv; valid_in = 1'b1;
    @(negedge clk);
    chk({tag, ".rdy"}, ready_out, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    readd1 = 8'($urandom); readd2 = 8'($urandom); sign_ext = 8'($urandom);
    if (!e.md) begin
      @(negedge clk);
      chk({tag, ".vld"}, valid_out, 1);
      chk({tag, ".res"}, alu_result, e.res);
      chk({tag, ".zero"}, zero, (e.res == 8'h00));
      chk({tag, ".ovf"}, ovf, e.ovf);
      chk({tag, ".wb"}, wb_en, e.wb);
      chk({tag, ".wreg"}, write_reg, wexp);
      chk({tag, ".bt"}, branch_target, btexp);
    end else begin
      low = 0; seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (c == 0) chk({tag, ".vld_n1"}, valid_out, 0);
        if (valid_out) begin seen = 1; break; end
        if (!ready_out) low++;
      end
      chk({tag, ".retired"}, seen, 1);
      chk({tag, ".stall"}, low, 9);
      chk({tag, ".rdy_ret"}, ready_out, 1);
      chk({tag, ".lo"}, alu_result, e.lo);
      chk({tag, ".zero"}, zero, (e.lo == 8'h00));
      chk({tag, ".wb"}, wb_en, 0);
      chk({tag, ".wreg"}, write_reg, wexp);
      chk({tag, ".bt"}, branch_target, btexp);
    end
    hi_m = e.hi; lo_m = e.lo;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".vld"}, valid_out, 0);
    chk({tag, ".wb"}, wb_en, 0);
    chk({tag, ".res"}, alu_result, 0);
    chk({tag, ".zero"}, zero, 0);
    chk({tag, ".ovf"}, ovf, 0);
    chk({tag, ".wreg"}, write_reg, 0);
    chk({tag, ".bt"}, branch_target, 0);
    chk({tag, ".rdy"}, ready_out, 1);
  endtask

  logic [5:0] fn_tab [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                              6'h10, 6'h12, 6'h18, 6'h1A, 6'h3F, 6'h00};
  logic [7:0] burst_res [6];
  logic [5:0] md_fn;
  int vcount;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0;
    readd1 = '0; readd2 = '0; sign_ext = '0; pc_next = '0; alu_op = '0; funct = '0;
    alu_src = 1'b0; reg_dst = 1'b0; rd = '0; rt = '0;
`ifdef EX_DIV_EN
    md_fn = 6'h1A;
`else
    md_fn = 6'h18;
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;

    exec("add_ovf",  2'b10, 6'h20, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b1);
    exec("slt_neg",  2'b10, 6'h2A, 8'hFE, 8'h03, 8'h10, 1'b0, 1'b0);
    exec("mult",     2'b10, 6'h18, 8'h07, 8'hFD, 8'h02, 1'b0, 1'b1);
    exec("mflo",     2'b10, 6'h12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("mfhi",     2'b10, 6'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("div_a",    2'b10, 6'h1A, 8'd100, 8'd7, 8'h00, 1'b0, 1'b1);
    exec("mflo_a",   2'b10, 6'h12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("mfhi_a",   2'b10, 6'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("div_b",    2'b10, 6'h1A, 8'hF9, 8'd2, 8'h00, 1'b0, 1'b1);
    exec("mfhi_b",   2'b10, 6'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("div_z",    2'b10, 6'h1A, 8'd5, 8'd0, 8'h00, 1'b0, 1'b1);
    exec("mfhi_z",   2'b10, 6'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("mflo_z",   2'b10, 6'h12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("addi",     2'b00, 6'h00, 8'h10, 8'h55, 8'hF0, 1'b1, 1'b0);
    exec("sub_ovf",  2'b01, 6'h00, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
    exec("sub_zero", 2'b10, 6'h22, 8'h33, 8'h33, 8'h00, 1'b0, 1'b1);
    exec("nor",      2'b10, 6'h27, 8'hA0, 8'h05, 8'h00, 1'b0, 1'b1);
    exec("unknown",  2'b10, 6'h3F, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
    exec("bt_wrap",  2'b00, 6'h00, 8'h01, 8'h00, 8'h7F, 1'b0, 1'b0);

    // Flush three cycles into a mult: nothing retires, HI/LO untouched.
    readd1 = 8'h09; readd2 = 8'h05; alu_op = 2'b10; funct = 6'h18; alu_src = 1'b0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush.rdy", ready_out, 1);
    chk("flush.vld", valid_out, 0);
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid_out) vcount++;
    end
    chk("flush.no_retire", vcount, 0);
    @(posedge clk); #1;
    exec("flush_mfhi", 2'b10, 6'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    exec("flush_mflo", 2'b10, 6'h12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

    // Flush together with valid_in drops the instruction.
    readd1 = 8'h01; readd2 = 8'h01; alu_op = 2'b00; valid_in = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_in.vld", valid_out, 0);
    @(posedge clk); #1;

    // Back-to-back single-cycle ops: one result per cycle.
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      readd1 = 8'($urandom); readd2 = 8'($urandom); alu_src = 1'b0;
      alu_op = 2'b10; funct = fn_tab[i % 4]; valid_in = 1'b1;
      e = model(alu_op, funct, readd1, readd2);
      burst_res[i] = e.res;
      @(negedge clk);
      chk("burst.rdy", ready_out, 1);
      if (i > 0) begin
        chk("burst.vld", valid_out, 1);
        chk("burst.res", alu_result, burst_res[i-1]);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    @(negedge clk);
    chk("burst.vld_last", valid_out, 1);
    chk("burst.res_last", alu_result, burst_res[5]);
    @(negedge clk);
    chk("burst.bubble", valid_out, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      exec("rand", 2'($urandom), fn_tab[$urandom_range(0, 11)], 8'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a multi-cycle op.
    readd1 = 8'd100; readd2 = 8'd7; alu_op = 2'b10; funct = md_fn; alu_src = 1'b0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    hi_m = 8'h00; lo_m = 8'h00;
    @(posedge clk); #1;
    exec("post_rst_add", 2'b10, 6'h20, 8'd2, 8'd3, 8'h00, 1'b0, 1'b1);
    exec("post_rst_mfhi", 2'b10, 6'h10, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
